// File: rtl/sst_sequencer_pkg.sv
// rtl/sst_sequencer_pkg.sv - shared mapper save-state types: bus struct, sequencer states, slot limit
package sst_sequencer_pkg;

    localparam int SST_SLOT_MAX = 128;

    typedef struct packed {
        logic       act;
        logic       we;
        logic [7:0] addr;
    } sst_bus_t;

    typedef enum logic [3:0] {
        IDLE,
        SV_ADDR,
        SV_CAP,
        SV_CK,
        LD_RD,
        LD_DAT,
        LD_WR,
        LD_CK,
        LD_CMP,
        FIN
    } sst_state_t;

endpackage

// File: rtl/sst_sequencer.sv
// rtl/sst_sequencer.sv - walks mapper registers to/from the state buffer; SST_CHECKSUM_EN adds an XOR check byte
module sst_sequencer
    import sst_sequencer_pkg::*;
#(
    parameter int REG_CNT = SST_SLOT_MAX
) (
    input  logic       clk,
    input  logic       map_rst,
    input  logic       start_save,
    input  logic       start_load,
    input  logic       m2_fall,
    output logic       busy,
    output logic       done,
    output logic       sst_act,
    output logic [7:0] sst_addr,
    output logic       sst_we_reg,
    output logic [7:0] sst_dato,
    input  logic [7:0] sst_di,
`ifdef SST_CHECKSUM_EN
    output logic       ck_err,
`endif
    output logic [7:0] buf_addr,
    output logic       buf_we,
    output logic [7:0] buf_wdat,
    input  logic [7:0] buf_rdat
);

    localparam logic [7:0] LAST_IDX = 8'(REG_CNT - 1);

`ifdef SST_CHECKSUM_EN
    localparam logic [7:0] CK_IDX = 8'(REG_CNT);
    localparam sst_state_t SV_END = SV_CK;
    localparam sst_state_t LD_END = LD_CK;
`else
    localparam sst_state_t SV_END = FIN;
    localparam sst_state_t LD_END = FIN;
`endif

    sst_state_t state, state_nxt;
    logic [7:0] idx, idx_nxt;
    logic [7:0] dato_q, dato_nxt;
    sst_bus_t   bus;

`ifdef SST_CHECKSUM_EN
    logic [7:0] ck_acc;
    logic       ck_err_q;

    // Accumulator restarts on an accepted start; load folds in every byte read back.
    always_ff @(posedge clk) begin
        if (map_rst) begin
            ck_acc   <= '0;
            ck_err_q <= 1'b0;
        end else if (state == IDLE && (start_save || start_load)) begin
            ck_acc   <= '0;
            ck_err_q <= 1'b0;
        end else if (state == SV_CAP) begin
            ck_acc <= ck_acc ^ sst_di;
        end else if (state == LD_DAT) begin
            ck_acc <= ck_acc ^ buf_rdat;
        end else if (state == LD_CMP) begin
            ck_err_q <= (ck_acc != buf_rdat);
        end
    end

    assign ck_err = ck_err_q;
`endif

    always_ff @(posedge clk) begin
        if (map_rst) begin
            state  <= IDLE;
            idx    <= '0;
            dato_q <= '0;
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            dato_q <= dato_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        dato_nxt  = dato_q;
        bus       = '0;
        buf_addr  = '0;
        buf_we    = 1'b0;
        buf_wdat  = '0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start_save) begin
                    state_nxt = SV_ADDR;
                    idx_nxt   = '0;
                end else if (start_load) begin
                    state_nxt = LD_RD;
                    idx_nxt   = '0;
                end
            end
            SV_ADDR: begin
                busy      = 1'b1;
                bus.act   = 1'b1;
                bus.addr  = idx;
                state_nxt = SV_CAP;
            end
            SV_CAP: begin
                busy     = 1'b1;
                bus.act  = 1'b1;
                bus.addr = idx;
                buf_addr = idx;
                buf_we   = 1'b1;
                buf_wdat = sst_di;
                if (idx == LAST_IDX) begin
                    state_nxt = SV_END;
                end else begin
                    idx_nxt   = idx + 8'd1;
                    state_nxt = SV_ADDR;
                end
            end
            LD_RD: begin
                busy      = 1'b1;
                bus.act   = 1'b1;
                buf_addr  = idx;
                state_nxt = LD_DAT;
            end
            LD_DAT: begin
                busy      = 1'b1;
                bus.act   = 1'b1;
                dato_nxt  = buf_rdat;
                state_nxt = LD_WR;
            end
            LD_WR: begin
                // The mapper write is held until the CPU bus cycle actually ends.
                busy     = 1'b1;
                bus.act  = 1'b1;
                bus.addr = idx;
                bus.we   = 1'b1;
                if (m2_fall) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = LD_END;
                    end else begin
                        idx_nxt   = idx + 8'd1;
                        state_nxt = LD_RD;
                    end
                end
            end
`ifdef SST_CHECKSUM_EN
            SV_CK: begin
                busy      = 1'b1;
                bus.act   = 1'b1;
                buf_addr  = CK_IDX;
                buf_we    = 1'b1;
                buf_wdat  = ck_acc;
                state_nxt = FIN;
            end
            LD_CK: begin
                busy      = 1'b1;
                bus.act   = 1'b1;
                buf_addr  = CK_IDX;
                state_nxt = LD_CMP;
            end
            LD_CMP: begin
                busy      = 1'b1;
                bus.act   = 1'b1;
                state_nxt = FIN;
            end
`endif
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign sst_act    = bus.act;
    assign sst_we_reg = bus.we;
    assign sst_addr   = bus.addr;
    assign sst_dato   = dato_q;

endmodule

// File: tb/tb_sst_sequencer.sv
// tb/tb_sst_sequencer.sv - directed and randomized save/load checks against mapper and buffer models
module tb_sst_sequencer;

    localparam int N = 3;
`ifdef SST_CHECKSUM_EN
    localparam int CK_EXTRA = 1;
`else
    localparam int CK_EXTRA = 0;
`endif

    logic       clk = 1'b0;
    logic       map_rst = 1'b1;
    logic       start_save = 1'b0;
    logic       start_load = 1'b0;
    logic       m2_fall = 1'b0;
    logic       busy, done, sst_act, sst_we_reg, buf_we;
    logic [7:0] sst_addr, sst_dato, sst_di, buf_addr, buf_wdat;
    logic [7:0] buf_rdat = 8'h00;
`ifdef SST_CHECKSUM_EN
    logic       ck_err;
    logic       ck_at_done = 1'b0;
`endif

    always #5 clk = ~clk;

    sst_sequencer #(.REG_CNT(N)) dut (
        .clk        (clk),
        .map_rst    (map_rst),
        .start_save (start_save),
        .start_load (start_load),
        .m2_fall    (m2_fall),
        .busy       (busy),
        .done       (done),
        .sst_act    (sst_act),
        .sst_addr   (sst_addr),
        .sst_we_reg (sst_we_reg),
        .sst_dato   (sst_dato),
        .sst_di     (sst_di),
`ifdef SST_CHECKSUM_EN
        .ck_err     (ck_err),
`endif
        .buf_addr   (buf_addr),
        .buf_we     (buf_we),
        .buf_wdat   (buf_wdat),
        .buf_rdat   (buf_rdat)
    );

    // Mapper register file and state buffer RAM (1-clk read latency).
    logic [7:0] mreg [256];
    logic [7:0] bmem [256];
    logic [7:0] pre_m [256];
    logic [7:0] pre_b [256];
    logic       load_m = 1'b0;
    logic       load_b = 1'b0;
    int         map_writes = 0;
    int         slot2_writes = 0;
    int         oob = 0;

    assign sst_di = mreg[sst_addr];

    always @(posedge clk) begin
        buf_rdat <= bmem[buf_addr];
        if (buf_we) begin
            bmem[buf_addr] = buf_wdat;
            if (int'(buf_addr) >= N + CK_EXTRA) oob++;
        end
        if (sst_we_reg && m2_fall) begin
            mreg[sst_addr] = sst_dato;
            map_writes++;
            if (sst_addr == 8'd2) slot2_writes++;
            if (int'(sst_addr) >= N) oob++;
        end
        if (load_m) mreg = pre_m;
        if (load_b) bmem = pre_b;
    end

    // M2 falling-edge strobe every 10 clocks while enabled.
    logic m2_en = 1'b0;
    int   m2_cnt = 0;
    always @(posedge clk) begin
        #1;
        m2_cnt++;
        m2_fall = m2_en && (m2_cnt % 10 == 0);
    end

    int   done_cnt = 0;
    int   we_viol = 0;
    logic prev_we = 1'b0;
    logic prev_m2 = 1'b0;
    always @(negedge clk) begin
        if (prev_we && !sst_we_reg && !prev_m2) we_viol++;
        prev_we = sst_we_reg;
        prev_m2 = m2_fall;
        if (done) begin
            done_cnt++;
`ifdef SST_CHECKSUM_EN
            ck_at_done = ck_err;
`endif
        end
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_map(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        for (int i = 0; i < 256; i++) pre_m[i] = 8'hA5;
        pre_m[0] = a; pre_m[1] = b; pre_m[2] = c;
        load_m = 1'b1;
        tick();
        load_m = 1'b0;
    endtask

    task automatic set_buf(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                           input logic [7:0] d);
        for (int i = 0; i < 256; i++) pre_b[i] = 8'h5A;
        pre_b[0] = a; pre_b[1] = b; pre_b[2] = c; pre_b[3] = d;
        load_b = 1'b1;
        tick();
        load_b = 1'b0;
    endtask

    // Pulses a start, optionally pulses both starts again at cycle inject_at, waits for done.
    task automatic run_seq(input bit is_save, input bit both, input int inject_at, output int n);
        start_save = is_save || both;
        start_load = !is_save || both;
        n = 0;
        do begin
            tick();
            start_save = 1'b0;
            start_load = 1'b0;
            n++;
            if (n == 1) check("busy_act_first_cycle", {busy, sst_act}, 2'b11);
            if (n == inject_at) begin
                start_save = 1'b1;
                start_load = 1'b1;
            end
        end while (!done && n < 2000);
        check("done_seen", done, 1'b1);
        tick();
        check("idle_after_done", {busy, sst_act, done}, 3'b000);
    endtask

    logic [7:0] x0, x1, x2;
    int         lat, d0, w0, v0, s0;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mreg[i] = 8'h00;
            bmem[i] = 8'h00;
        end
        tick(); tick(); tick();
        check("reset_outputs",
              {busy, done, sst_act, sst_addr, sst_we_reg, sst_dato, buf_addr, buf_we, buf_wdat}, '0);
        map_rst = 1'b0;
        tick();
        check("idle_outputs",
              {busy, done, sst_act, sst_addr, sst_we_reg, sst_dato, buf_addr, buf_we, buf_wdat}, '0);

        // Directed save
        set_map(8'h05, 8'h0A, 8'h01);
        set_buf(8'h5A, 8'h5A, 8'h5A, 8'h5A);
        d0 = done_cnt; w0 = map_writes;
        run_seq(1'b1, 1'b0, 0, lat);
        check("save_latency", lat, 2 * N + 1 + CK_EXTRA);
        check("save_buf0", bmem[0], 8'h05);
        check("save_buf1", bmem[1], 8'h0A);
        check("save_buf2", bmem[2], 8'h01);
        check("save_buf3", bmem[3], (CK_EXTRA != 0) ? 8'h0E : 8'h5A);
        check("save_done_pulses", done_cnt - d0, 1);
        check("save_no_map_writes", map_writes - w0, 0);

        // Directed load, m2_fall every 10 clk
        m2_en = 1'b1;
        set_map(8'h00, 8'h00, 8'h00);
        set_buf(8'h07, 8'h4F, 8'h01, 8'h49);
        d0 = done_cnt; w0 = map_writes; v0 = we_viol;
        run_seq(1'b0, 1'b0, 0, lat);
        check("load_reg0", mreg[0], 8'h07);
        check("load_reg1", mreg[1], 8'h4F);
        check("load_reg2", mreg[2], 8'h01);
        check("load_map_writes", map_writes - w0, N);
        check("load_we_ends_on_m2", we_viol - v0, 0);
        check("load_done_pulses", done_cnt - d0, 1);
`ifdef SST_CHECKSUM_EN
        check("load_ck_ok", ck_at_done, 1'b0);
`endif

        // start_load pulsed during save is ignored
        set_map(8'h33, 8'hC4, 8'h9E);
        set_buf(8'h00, 8'h00, 8'h00, 8'h00);
        d0 = done_cnt; w0 = map_writes;
        run_seq(1'b1, 1'b0, 2, lat);
        check("inject_latency", lat, 2 * N + 1 + CK_EXTRA);
        check("inject_buf0", bmem[0], 8'h33);
        check("inject_buf1", bmem[1], 8'hC4);
        check("inject_buf2", bmem[2], 8'h9E);
        check("inject_done_pulses", done_cnt - d0, 1);
        check("inject_no_map_writes", map_writes - w0, 0);

        // Both starts together act as save
        set_map(8'h11, 8'h22, 8'h44);
        w0 = map_writes;
        run_seq(1'b1, 1'b1, 0, lat);
        check("both_buf0", bmem[0], 8'h11);
        check("both_buf2", bmem[2], 8'h44);
        check("both_no_map_writes", map_writes - w0, 0);

        // Reset while slot 1 of a load is writing
        set_map(8'hA5, 8'hA5, 8'hA5);
        set_buf(8'h61, 8'h62, 8'h63, 8'h00);
        d0 = done_cnt; s0 = slot2_writes;
        start_load = 1'b1;
        lat = 0;
        do begin
            tick();
            start_load = 1'b0;
            lat++;
        end while (!(sst_we_reg && sst_addr == 8'd1) && lat < 500);
        check("reach_slot1_write", {sst_we_reg, sst_addr}, {1'b1, 8'd1});
        map_rst = 1'b1;
        tick();
        check("abort_outputs",
              {busy, done, sst_act, sst_addr, sst_we_reg, sst_dato, buf_addr, buf_we, buf_wdat}, '0);
        map_rst = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_no_slot2_write", slot2_writes - s0, 0);
        check("abort_slot2_value", mreg[2], 8'hA5);

        // Randomized save/load round trips against the array model
        for (int it = 0; it < 4; it++) begin
            x0 = 8'($urandom); x1 = 8'($urandom); x2 = 8'($urandom);
            set_map(x0, x1, x2);
            set_buf(8'h00, 8'h00, 8'h00, 8'h00);
            run_seq(1'b1, 1'b0, 0, lat);
            check("rnd_save_latency", lat, 2 * N + 1 + CK_EXTRA);
            check("rnd_save_bytes", {bmem[0], bmem[1], bmem[2]}, {x0, x1, x2});
`ifdef SST_CHECKSUM_EN
            check("rnd_save_ck", bmem[3], x0 ^ x1 ^ x2);
`endif
            x0 = 8'($urandom); x1 = 8'($urandom); x2 = 8'($urandom);
            set_buf(x0, x1, x2, x0 ^ x1 ^ x2);
            set_map(~x0, ~x1, ~x2);
            v0 = we_viol;
            run_seq(1'b0, 1'b0, 0, lat);
            check("rnd_load_bytes", {mreg[0], mreg[1], mreg[2]}, {x0, x1, x2});
            check("rnd_load_we_ends_on_m2", we_viol - v0, 0);
`ifdef SST_CHECKSUM_EN
            check("rnd_load_ck_ok", ck_at_done, 1'b0);
`endif
        end

`ifdef SST_CHECKSUM_EN
        // Corrupted buffer byte must flag a checksum error
        set_buf(8'h05, 8'h0B, 8'h01, 8'h0E);
        run_seq(1'b0, 1'b0, 0, lat);
        check("ck_err_on_corrupt", ck_at_done, 1'b1);
`endif

        check("no_out_of_range_writes", oob, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
